// File: rtl/nvic_arb.sv
// Nested interrupt arbiter: edge/strobe-driven pending and enable registers,
// fixed-priority winner selection with strict preemption, and a bounded
// stack of active handlers driven by ack/eoi from the core.
module nvic_arb #(
   parameter int unsigned NUM_IRQ    = 8,
   parameter int unsigned PRIO_BITS  = 2,
   parameter int unsigned NEST_DEPTH = 4,
   localparam int unsigned ID_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_IRQ-1:0]             irq_in,
   input  logic [NUM_IRQ-1:0]             en_set,
   input  logic [NUM_IRQ-1:0]             en_clr,
   input  logic [NUM_IRQ-1:0]             pend_set,
   input  logic [NUM_IRQ-1:0]             pend_clr,
   input  logic [NUM_IRQ*PRIO_BITS-1:0]   prio_in,
   input  logic                           irq_ack,
   input  logic                           irq_eoi,
   output logic                           irq_req,
   output logic [ID_W-1:0]                irq_id,
   output logic [PRIO_BITS-1:0]           irq_prio,
   output logic                           active,
   output logic [ID_W-1:0]                active_id,
   output logic [NUM_IRQ-1:0]             enable_q,
   output logic [NUM_IRQ-1:0]             pending_q
);

   localparam int unsigned LVL_W = $clog2(NEST_DEPTH + 1);
   localparam int unsigned STK_N = 1 << LVL_W;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [ID_W-1:0]        cur_id_q, cur_id_d;
   logic [PRIO_BITS-1:0]   cur_prio_q, cur_prio_d;
   logic [NUM_IRQ-1:0]     act_mask_q, act_mask_d;
   logic [ID_W-1:0]        stk_id_q   [STK_N];
   logic [ID_W-1:0]        stk_id_d   [STK_N];
   logic [PRIO_BITS-1:0]   stk_prio_q [STK_N];
   logic [PRIO_BITS-1:0]   stk_prio_d [STK_N];
   logic [NUM_IRQ-1:0]     irq_q;
   logic [NUM_IRQ-1:0]     en_q, en_d;
   logic [NUM_IRQ-1:0]     pend_q, pend_d;
   logic                   req_q, req_d;
   logic [ID_W-1:0]        id_q, id_d;
   logic [PRIO_BITS-1:0]   prio_q, prio_d;

   logic [NUM_IRQ-1:0]     cand;
   logic                   win_found;
   logic [ID_W-1:0]        win_id;
   logic [PRIO_BITS-1:0]   win_prio;
   logic                   offer_ok;
   logic                   ack_ok;
   logic                   eoi_ok;
   logic [NUM_IRQ-1:0]     ack_mask;
   logic [NUM_IRQ-1:0]     cur_mask;

   // Accepted handshakes; an eoi in the same cycle always suppresses the ack
   assign ack_ok = irq_ack & req_q & ~irq_eoi;
   assign eoi_ok = irq_eoi & (state_q == ST_ACTIVE);

   // Pick the most urgent eligible line, lowest index on equal priority
   always_comb begin
      cand      = pend_q & en_q & ~act_mask_q;
      win_found = 1'b0;
      win_id    = '0;
      win_prio  = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (cand[i] && (!win_found || (prio_in[i*PRIO_BITS +: PRIO_BITS] < win_prio))) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
            win_prio  = prio_in[i*PRIO_BITS +: PRIO_BITS];
         end
      end
      offer_ok = win_found &&
                 ((state_q == ST_IDLE) ||
                  ((win_prio < cur_prio_q) && (level_q < LVL_W'(NEST_DEPTH))));
   end

   // One-hot masks for the offered line and the innermost active line
   always_comb begin
      ack_mask = '0;
      cur_mask = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         ack_mask[i] = ack_ok && (id_q == ID_W'(i));
         cur_mask[i] = (cur_id_q == ID_W'(i));
      end
   end

   // Enable and pending updates; set sources dominate for pending, clear for enable
   always_comb begin
      en_d   = (en_q | en_set) & ~en_clr;
      pend_d = (pend_q & ~(pend_clr | ack_mask)) | pend_set | (irq_in & ~irq_q);
   end

   // Handler nesting FSM plus registered offer outputs
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      cur_id_d   = cur_id_q;
      cur_prio_d = cur_prio_q;
      act_mask_d = act_mask_q;
      stk_id_d   = stk_id_q;
      stk_prio_d = stk_prio_q;
      req_d      = offer_ok & ~ack_ok & ~eoi_ok;
      id_d       = req_d ? win_id : '0;
      prio_d     = req_d ? win_prio : '0;

      case (state_q)
         ST_IDLE: begin
            if (ack_ok) begin
               state_d    = ST_ACTIVE;
               level_d    = LVL_W'(1);
               cur_id_d   = id_q;
               cur_prio_d = prio_q;
               act_mask_d = act_mask_q | ack_mask;
            end
         end
         ST_ACTIVE: begin
            if (eoi_ok) begin
               act_mask_d = act_mask_q & ~cur_mask;
               level_d    = level_q - LVL_W'(1);
               if (level_q == LVL_W'(1)) begin
                  state_d    = ST_IDLE;
                  cur_id_d   = '0;
                  cur_prio_d = '0;
               end else begin
                  cur_id_d   = stk_id_q[LVL_W'(level_q - LVL_W'(2))];
                  cur_prio_d = stk_prio_q[LVL_W'(level_q - LVL_W'(2))];
               end
            end else if (ack_ok) begin
               stk_id_d[LVL_W'(level_q - LVL_W'(1))]   = cur_id_q;
               stk_prio_d[LVL_W'(level_q - LVL_W'(1))] = cur_prio_q;
               cur_id_d   = id_q;
               cur_prio_d = prio_q;
               level_d    = level_q + LVL_W'(1);
               act_mask_d = act_mask_q | ack_mask;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any in-flight handler stack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         level_q    <= '0;
         cur_id_q   <= '0;
         cur_prio_q <= '0;
         act_mask_q <= '0;
         for (int i = 0; i < STK_N; i++) begin
            stk_id_q[i]   <= '0;
            stk_prio_q[i] <= '0;
         end
         irq_q      <= '0;
         en_q       <= '0;
         pend_q     <= '0;
         req_q      <= 1'b0;
         id_q       <= '0;
         prio_q     <= '0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         cur_id_q   <= cur_id_d;
         cur_prio_q <= cur_prio_d;
         act_mask_q <= act_mask_d;
         stk_id_q   <= stk_id_d;
         stk_prio_q <= stk_prio_d;
         irq_q      <= irq_in;
         en_q       <= en_d;
         pend_q     <= pend_d;
         req_q      <= req_d;
         id_q       <= id_d;
         prio_q     <= prio_d;
      end
   end

   assign irq_req   = req_q;
   assign irq_id    = id_q;
   assign irq_prio  = prio_q;
   assign active    = (state_q == ST_ACTIVE);
   assign active_id = cur_id_q;
   assign enable_q  = en_q;
   assign pending_q = pend_q;

endmodule

// File: tb/tb_nvic_arb.sv
// Bench for nvic_arb: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the arbiter.
module tb_nvic_arb;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_in, en_set, en_clr, pend_set, pend_clr;
   logic [15:0] prio_in;
   logic        irq_ack, irq_eoi;
   logic        irq_req, active;
   logic [2:0]  irq_id, active_id;
   logic [1:0]  irq_prio;
   logic [7:0]  enable_q, pending_q;
   logic        u2_req, u2_active;
   logic [2:0]  u2_id, u2_active_id;
   logic [1:0]  u2_prio;
   logic [7:0]  u2_enable_q, u2_pending_q;

   int n_checks = 0;
   int n_err    = 0;

   // Model state
   logic [7:0] m_en, m_pend, m_prev;
   int         m_stk[$];
   int         m_sprio[$];
   bit         m_req;
   int         m_id, m_prio;

   always #5 clk = ~clk;

   nvic_arb #(.NUM_IRQ(8), .PRIO_BITS(2), .NEST_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .en_set(en_set), .en_clr(en_clr),
      .pend_set(pend_set), .pend_clr(pend_clr), .prio_in(prio_in),
      .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_req(irq_req), .irq_id(irq_id),
      .irq_prio(irq_prio), .active(active), .active_id(active_id),
      .enable_q(enable_q), .pending_q(pending_q));

   nvic_arb #(.NUM_IRQ(8), .PRIO_BITS(2), .NEST_DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .irq_in(irq_in), .en_set(en_set), .en_clr(en_clr),
      .pend_set(pend_set), .pend_clr(pend_clr), .prio_in(prio_in),
      .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_req(u2_req), .irq_id(u2_id),
      .irq_prio(u2_prio), .active(u2_active), .active_id(u2_active_id),
      .enable_q(u2_enable_q), .pending_q(u2_pending_q));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int prio_of(input int line);
      return int'((prio_in >> (2 * line)) & 16'h3);
   endfunction

   task automatic model_reset();
      m_en = '0; m_pend = '0; m_prev = '0;
      m_stk.delete(); m_sprio.delete();
      m_req = 1'b0; m_id = 0; m_prio = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven
   task automatic model_step();
      logic [7:0] actm, cand, ackm;
      int  best, bkey, key;
      bit  qual, ack_ok, eoi_ok;
      actm = '0;
      foreach (m_stk[k]) actm[m_stk[k]] = 1'b1;
      cand = m_pend & m_en & ~actm;
      best = -1;
      bkey = 1 << 30;
      for (int i = 0; i < 8; i++) begin
         if (cand[i]) begin
            key = prio_of(i) * 8 + i;
            if (key < bkey) begin bkey = key; best = i; end
         end
      end
      qual = (best >= 0) &&
             (m_stk.size() == 0 ||
              (prio_of(best) < m_sprio[$] && m_stk.size() < DEPTH));
      ack_ok = irq_ack && m_req && !irq_eoi;
      eoi_ok = irq_eoi && (m_stk.size() > 0);
      ackm   = ack_ok ? 8'(1 << m_id) : 8'h00;
      m_en   = (m_en | en_set) & ~en_clr;
      m_pend = (m_pend & ~pend_clr & ~ackm) | pend_set | (irq_in & ~m_prev);
      m_prev = irq_in;
      if (eoi_ok) begin
         void'(m_stk.pop_back());
         void'(m_sprio.pop_back());
      end else if (ack_ok) begin
         m_stk.push_back(m_id);
         m_sprio.push_back(m_prio);
      end
      m_req  = qual && !ack_ok && !eoi_ok;
      m_id   = m_req ? best : 0;
      m_prio = m_req ? prio_of(best) : 0;
   endtask

   task automatic compare_all();
      chk("irq_req",   32'(irq_req),   32'(m_req));
      chk("irq_id",    32'(irq_id),    32'(m_id));
      chk("irq_prio",  32'(irq_prio),  32'(m_prio));
      chk("active",    32'(active),    32'(m_stk.size() > 0));
      chk("active_id", 32'(active_id), 32'((m_stk.size() > 0) ? m_stk[$] : 0));
      chk("enable_q",  32'(enable_q),  32'(m_en));
      chk("pending_q", 32'(pending_q), 32'(m_pend));
   endtask

   // One clock: model, edge, compare, then drop the one-cycle strobes
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      en_set = '0; en_clr = '0; pend_set = '0; pend_clr = '0;
      irq_ack = 1'b0; irq_eoi = 1'b0;
   endtask

   task automatic set_prio(input int line, input int p);
      prio_in[2*line +: 2] = 2'(p);
   endtask

   task automatic do_reset();
      irq_in = '0;
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_req",    32'(irq_req),   32'd0);
      chk("rst_active", 32'(active),    32'd0);
      chk("rst_pend",   32'(pending_q), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Pend a line, let it be offered, and acknowledge it
   task automatic offer_ack(input int line, input string tag);
      pend_set = 8'(1 << line);
      step();
      step();
      chk({tag, "_req"}, 32'(irq_req), 32'd1);
      chk({tag, "_id"},  32'(irq_id),  32'(line));
      irq_ack = 1'b1;
      step();
   endtask

   initial begin
      rst = 1'b0;
      irq_in = '0; en_set = '0; en_clr = '0; pend_set = '0; pend_clr = '0;
      prio_in = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
      model_reset();
      #2;
      chk("reset_req",       32'(irq_req),   32'd0);
      chk("reset_id",        32'(irq_id),    32'd0);
      chk("reset_active_id", 32'(active_id), 32'd0);
      chk("reset_enable",    32'(enable_q),  32'd0);
      do_reset();

      // Basic priority selection
      set_prio(1, 2); set_prio(2, 1);
      en_set = 8'h06; pend_set = 8'h06;
      step();
      step();
      chk("r37_req",  32'(irq_req),  32'd1);
      chk("r37_id",   32'(irq_id),   32'd2);
      chk("r37_prio", 32'(irq_prio), 32'd1);
      pend_clr = 8'h06; en_clr = 8'h06;
      step();
      step();

      // Equal priority: lowest index first, no preemption by the other
      set_prio(3, 1); set_prio(5, 1);
      en_set = 8'h28; pend_set = 8'h28;
      step();
      step();
      chk("r38_first", 32'(irq_id), 32'd3);
      irq_ack = 1'b1;
      step();
      chk("r38_active_id", 32'(active_id), 32'd3);
      step(); step(); step();
      chk("r38_no_preempt", 32'(irq_req), 32'd0);
      irq_eoi = 1'b1;
      step();
      step();
      chk("r38_after_eoi_req", 32'(irq_req), 32'd1);
      chk("r38_after_eoi_id",  32'(irq_id),  32'd5);
      irq_ack = 1'b1; step();
      irq_eoi = 1'b1; step();

      // Preemption and unwinding
      set_prio(4, 2); set_prio(0, 0);
      en_set = 8'h11;
      offer_ack(4, "r39_l4");
      chk("r39_active4", 32'(active_id), 32'd4);
      pend_set = 8'h01;
      step();
      step();
      chk("r39_pre_req",  32'(irq_req),  32'd1);
      chk("r39_pre_id",   32'(irq_id),   32'd0);
      chk("r39_pre_prio", 32'(irq_prio), 32'd0);
      irq_ack = 1'b1; step();
      chk("r39_active0", 32'(active_id), 32'd0);
      irq_eoi = 1'b1; step();
      chk("r39_back4", 32'(active_id), 32'd4);
      irq_eoi = 1'b1; step();
      chk("r39_idle", 32'(active), 32'd0);

      // Set-vs-clear precedence, and pending held while disabled
      set_prio(1, 2);
      irq_in = 8'h02; pend_clr = 8'h02;
      step();
      chk("r41_pend_wins", 32'(pending_q[1]), 32'd1);
      en_set = 8'h02; step();
      en_set = 8'h02; en_clr = 8'h02; step();
      chk("r41_en_clr_wins", 32'(enable_q[1]), 32'd0);
      irq_in = 8'h00;
      step(); step(); step();
      chk("r34_held_pend", 32'(pending_q[1]), 32'd1);
      chk("r34_not_offered", 32'(irq_req), 32'd0);
      en_set = 8'h02; step(); step();
      chk("r34_reenabled_id", 32'(irq_id), 32'd1);
      irq_ack = 1'b1; step();
      irq_eoi = 1'b1; step();

      // Three nested handlers, then asynchronous reset mid-handler
      set_prio(6, 3); set_prio(7, 2); set_prio(2, 1);
      en_set = 8'hC4;
      offer_ack(6, "r42_l6");
      offer_ack(7, "r42_l7");
      offer_ack(2, "r42_l2");
      chk("r42_nested", 32'(active_id), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("r42_async_active", 32'(active),    32'd0);
      chk("r42_async_aid",    32'(active_id), 32'd0);
      chk("r42_async_req",    32'(irq_req),   32'd0);
      chk("r42_async_en",     32'(enable_q),  32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(); step();
      chk("r42_quiet", 32'(irq_req), 32'd0);

      // Nest depth limit on the depth-2 instance
      set_prio(0, 3); set_prio(1, 2); set_prio(2, 1);
      en_set = 8'h07;
      pend_set = 8'h01; step(); step();
      chk("r40_d2_id0", 32'(u2_id), 32'd0);
      irq_ack = 1'b1; step();
      pend_set = 8'h02; step(); step();
      chk("r40_d2_id1", 32'(u2_id), 32'd1);
      irq_ack = 1'b1; step();
      chk("r40_d2_active1", 32'(u2_active_id), 32'd1);
      pend_set = 8'h04; step(); step(); step();
      chk("r40_d2_blocked", 32'(u2_req), 32'd0);
      irq_eoi = 1'b1; step();
      step();
      chk("r40_d2_req_after_eoi", 32'(u2_req), 32'd1);
      chk("r40_d2_id2",           32'(u2_id),  32'd2);
      irq_ack = 1'b1; step();
      irq_eoi = 1'b1; step();
      irq_eoi = 1'b1; step();

      // Random traffic against the model
      do_reset();
      prio_in = 16'($urandom);
      for (int c = 0; c < 400; c++) begin
         en_set   = 8'($urandom) & 8'($urandom) & 8'($urandom);
         en_clr   = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
         pend_set = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
         pend_clr = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
         irq_in   = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 19) == 0) prio_in = 16'($urandom);
         irq_ack  = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         irq_eoi  = (m_stk.size() > 0) ? ($urandom_range(0, 6) == 0)
                                       : ($urandom_range(0, 19) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
